// File: rtl/mrly_diag_spi_core_if.sv
// SPI link between the microcontroller (master) and the relay-card diagnostic core (slave).
// All four lines are plain logic; MISO is always driven by the slave.
interface mrly_diag_spi_core_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/mrly_diag_spi_core.sv
// Relay-card housekeeping: TPIC clock divider, heartbeat LED and a mode-0 SPI slave
// that streams the flat relay memory byte-wise. Everything runs in the clk domain.
module mrly_diag_spi_core #(
    parameter int WIDTH           = 432,
    parameter int DIVISOR         = 4,
    parameter int LED_HALF_PERIOD = 12500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     memory,
    output logic                 clk_div,
    output logic                 live_led,
    mrly_diag_spi_core_if.slave  spi
);

    localparam int HALF_DIV = DIVISOR / 2;
    localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int LED_W    = (LED_HALF_PERIOD > 1) ? $clog2(LED_HALF_PERIOD) : 1;
    localparam int IDX_W    = $clog2(WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_HALF_PERIOD - 1);
    localparam logic [16:0]      NBYTES   = 17'(WIDTH / 8);
    localparam logic [7:0]       CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_SKIP = 3'd4
    } spi_state_e;

    // Byte n of the relay memory, or 0x00 beyond the end of the memory.
    function automatic logic [7:0] byte_at(input logic [WIDTH-1:0] mem, input logic [15:0] a);
        logic [IDX_W-1:0] idx;
        logic [7:0]       b;
        idx = IDX_W'({a, 3'b000});
        if ({1'b0, a} < NBYTES) begin
            b = mem[idx +: 8];
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             clk_div_q, clk_div_d;
    logic [LED_W-1:0] led_cnt_q, led_cnt_d;
    logic             led_q, led_d;

    // Divider and heartbeat next-state: both toggle on counter wrap.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        clk_div_d = clk_div_q;
        led_cnt_d = led_cnt_q + LED_W'(1);
        led_d     = led_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            clk_div_d = ~clk_div_q;
        end else begin
            clk_div_d = clk_div_q;
        end
        if (led_cnt_q == LED_LAST) begin
            led_cnt_d = '0;
            led_d     = ~led_q;
        end else begin
            led_d = led_q;
        end
    end

    // Divider and heartbeat registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            clk_div_q <= 1'b0;
            led_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clk_div_q <= clk_div_d;
            led_cnt_q <= led_cnt_d;
            led_q     <= led_d;
        end
    end

    assign clk_div  = clk_div_q;
    assign live_led = led_q;

    // sclk gets a third stage so edges can be detected on the synchronized copy.
    logic [2:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    // SPI input synchronizers; chip select comes out of reset deselected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi.spi_sclk};
            cs_sync_q   <= {cs_sync_q[0], spi.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
        end
    end

    logic sclk_rise_s, sclk_fall_s, cs_high_s, mosi_s;
    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_high_s   = cs_sync_q[1];
    assign mosi_s      = mosi_sync_q[1];

    spi_state_e  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  shift_q, shift_d;
    logic        miso_q, miso_d;

    logic [7:0]  cmd_next_s;
    logic [15:0] addr_next_s;
    logic [15:0] addr_inc_s;
    assign cmd_next_s  = {cmd_q[6:0], mosi_s};
    assign addr_next_s = {addr_q[14:0], mosi_s};
    assign addr_inc_s  = addr_q + 16'd1;

    // SPI FSM next-state; a deselect overrides every state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        miso_d    = miso_q;
        if (cs_high_s) begin
            state_d   = S_IDLE;
            bit_cnt_d = 5'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_CMD;
                    bit_cnt_d = 5'd0;
                    miso_d    = 1'b0;
                end
                S_CMD: begin
                    miso_d = 1'b0;
                    if (sclk_rise_s) begin
                        cmd_d = cmd_next_s;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            state_d   = (cmd_next_s == CMD_READ) ? S_ADDR : S_SKIP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        cmd_d = cmd_q;
                    end
                end
                S_ADDR: begin
                    miso_d = 1'b0;
                    if (sclk_rise_s) begin
                        addr_d = addr_next_s;
                        if (bit_cnt_q == 5'd15) begin
                            bit_cnt_d = 5'd0;
                            shift_d   = byte_at(memory, addr_next_s);
                            state_d   = S_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        addr_d = addr_q;
                    end
                end
                S_DATA: begin
                    // The last bit of a byte goes out on the same edge that loads the next byte.
                    if (sclk_fall_s) begin
                        miso_d = shift_q[7];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = addr_inc_s;
                            shift_d   = byte_at(memory, addr_inc_s);
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                        end
                    end else begin
                        miso_d = miso_q;
                    end
                end
                S_SKIP: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d   = S_IDLE;
                    bit_cnt_d = 5'd0;
                    miso_d    = 1'b0;
                end
            endcase
        end
    end

    // SPI FSM and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 5'd0;
            cmd_q     <= 8'h00;
            addr_q    <= 16'h0000;
            shift_q   <= 8'h00;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            miso_q    <= miso_d;
        end
    end

    assign spi.spi_miso = miso_q;

endmodule

// File: tb/tb_mrly_diag_spi_core.sv
// Bench for mrly_diag_spi_core: divider/LED timing after reset, then SPI reads checked
// against a byte model through a queue of expected MISO bits.
module tb_mrly_diag_spi_core;

    localparam int WIDTH  = 432;
    localparam int NBYTES = WIDTH / 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] memory;
    logic             clk_div;
    logic             live_led;
    logic [7:0]       mem_b [NBYTES];
    bit               exp_q [$];
    int               err_cnt;
    int               chk_cnt;

    mrly_diag_spi_core_if spi_if ();

    mrly_diag_spi_core #(
        .WIDTH           (WIDTH),
        .DIVISOR         (4),
        .LED_HALF_PERIOD (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memory   (memory),
        .clk_div  (clk_div),
        .live_led (live_led),
        .spi      (spi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_byte(input int idx, input logic [7:0] v);
        mem_b[idx] = v;
        memory[idx*8 +: 8] = v;
    endtask

    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        if (a < 16'(NBYTES)) return mem_b[a];
        return 8'h00;
    endfunction

    // Runs 24+nclk SCLK periods (nclk<0 = truncated header). At k==poke_k the first
    // addressed byte is overwritten; at k==rst_k reset is pulsed mid-transfer.
    task automatic spi_xfer(input logic [23:0] hdr, input int nclk, input int poke_k, input int rst_k);
        logic [7:0]  cmd;
        logic [15:0] a;
        logic [7:0]  b;
        int          total;
        int          off;
        bit          e;
        cmd   = hdr[23:16];
        a     = hdr[15:0];
        total = 24 + nclk;
        for (int k = 1; k <= total; k++) begin
            if (k >= 24 && cmd == 8'h03) begin
                off = k - 24;
                b   = exp_byte(a + 16'(off / 8));
                exp_q.push_back(b[7 - (off % 8)]);
            end else begin
                exp_q.push_back(1'b0);
            end
        end
        spi_if.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 1; k <= total; k++) begin
            spi_if.spi_mosi = (k <= 24) ? hdr[24 - k] : 1'b0;
            repeat (5) @(negedge clk);
            spi_if.spi_sclk = 1'b1;
            repeat (5) @(negedge clk);
            spi_if.spi_sclk = 1'b0;
            repeat (5) @(negedge clk);
            if (exp_q.size() == 0) begin
                check_val("queue_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val($sformatf("miso_%06h_k%0d", hdr, k), {31'd0, spi_if.spi_miso}, {31'd0, e});
            end
            if (k == poke_k) set_byte(int'(a), 8'hFF);
            if (k == rst_k) begin
                reset = 1'b0;
                #1;
                check_val("miso_on_reset", {31'd0, spi_if.spi_miso}, 32'd0);
                spi_if.spi_cs_n = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b1;
                exp_q.delete();
                break;
            end
        end
        spi_if.spi_mosi = 1'b0;
        spi_if.spi_sclk = 1'b0;
        spi_if.spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("miso_idle", {31'd0, spi_if.spi_miso}, 32'd0);
    endtask

    initial begin
        err_cnt         = 0;
        chk_cnt         = 0;
        reset           = 1'b0;
        memory          = '0;
        spi_if.spi_sclk = 1'b0;
        spi_if.spi_cs_n = 1'b1;
        spi_if.spi_mosi = 1'b0;
        for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
        repeat (4) @(negedge clk);
        check_val("rst_clk_div", {31'd0, clk_div}, 32'd0);
        check_val("rst_led", {31'd0, live_led}, 32'd0);
        check_val("rst_miso", {31'd0, spi_if.spi_miso}, 32'd0);

        // clk_div toggles every 2 cycles, live_led every 10, counted from release.
        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n <= 16) check_val($sformatf("clk_div_c%0d", n), {31'd0, clk_div}, 32'((n / 2) % 2));
            check_val($sformatf("led_c%0d", n), {31'd0, live_led}, 32'((n / 10) % 2));
        end

        set_byte(7, 8'h55);
        spi_xfer(24'h030007, 8, 0, 0);

        set_byte(6, 8'hA5);
        set_byte(7, 8'h3C);
        spi_xfer(24'h030006, 16, 26, 0);
        set_byte(6, 8'hA5);

        spi_xfer(24'h0300FF, 8, 0, 0);

        set_byte(53, 8'h9E);
        spi_xfer(24'h030035, 16, 0, 0);

        set_byte(0, 8'h81);
        spi_xfer(24'h03FFFF, 16, 0, 0);

        spi_xfer(24'h020007, 8, 0, 0);

        set_byte(7, 8'h55);
        spi_xfer(24'h030007, -12, 0, 0);
        spi_xfer(24'h030007, 8, 0, 0);

        spi_xfer(24'h030007, 8, 0, 27);
        spi_xfer(24'h030007, 8, 0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
